mic1_control_store: RTL and testbench
=====================================

Name: mic1_control_store

Overview:
- Microprogram control store for the MIC-1 control path. It is the other end of the MPC/MIR interface: it consumes MPC from the control path and returns the registered 36-bit microinstruction MIR.
- MIR[35:27] is NEXT_ADDRESS and MIR[26:24] is JMPC/JAMN/JAMZ; the control path reads those bits back.
- Before execution, a handshaked load port writes the microprogram into the store. A small FSM sequences the load phase and the run phase.

Parameters:
- ADDR_W, 9, width of MPC and of the load address.
- WORD_W, 36, microinstruction width.
- DEPTH, 512, number of store words (must equal 2**ADDR_W).

Ports:
- clk  in  1  system clock, all state changes on rising edge.
- rst  in  1  synchronous, active-low reset.
- MPC  in  ADDR_W  microprogram counter from the control path.
- hold  in  1  freezes MIR during a run (memory wait).
- load_valid  in  1  loader presents a word.
- load_ready  out  1  store accepts a word this cycle.
- load_addr  in  ADDR_W  target address of the load word.
- load_data  in  WORD_W  microinstruction to write.
- load_last  in  1  marks the final load word.
- run_start  in  1  go directly from IDLE to RUN without loading.
- running  out  1  high in RUN.
- word_count  out  ADDR_W+1  number of words accepted since the last reset.
- MIR  out  WORD_W  registered microinstruction.

Behaviour:
- Reset (rst==0 at a rising edge):
  - State goes to IDLE; MIR=0, word_count=0, running=0.
  - Store contents are NOT cleared; reset mid-load keeps the words already written.
- IDLE:
  - load_ready=1.
  - A load_valid handshake writes the word and goes to LOAD; if load_last is also high, go straight to RUN.
  - Otherwise, run_start goes to RUN.
  - load_valid and run_start together: the load wins and run_start is ignored.
- LOAD:
  - load_ready=1; every cycle with load_valid=1 writes mem[load_addr]=load_data and increments word_count.
  - word_count saturates at DEPTH.
  - A handshake with load_last=1 writes the word and goes to RUN on the next cycle.
  - MIR stays 0 throughout.
- RUN:
  - load_ready=0; load_valid is ignored and no write occurs.
  - running=1. MIR <= mem[MPC] on each rising edge where hold=0, so latency is 1 cycle from MPC to MIR.
  - With hold=1, MIR holds its value.
  - RUN is left only by reset.
- Write/read collision: impossible by construction, because writes happen only outside RUN.
- Address wrap: none needed; the full ADDR_W range is valid. Repeated writes to one address: the last write wins, and every accepted word still counts.
- Unwritten locations read as X in simulation. The bench initialises every location it reads.

Optional Feature:
- Macro MIC1_CS_PARITY_EN.
- With it defined:
  - Each store word carries an extra even-parity bit, computed at write time over load_data.
  - Each RUN fetch checks parity. On a mismatch, MIR is forced to 0 (NEXT_ADDRESS 0, no jump) and the sticky output parity_err (1 bit) is set.
  - parity_err is cleared only by reset.
- Without it: no parity storage, no parity_err port, and fetch is unchecked.

Decomposition:
- Shared package mic1_pkg holds:
  - ADDR_W and WORD_W;
  - the MIR field localparams (NEXT_ADDR_MSB=35, NEXT_ADDR_LSB=27, JMPC_BIT=26, JAMN_BIT=25, JAMZ_BIT=24);
  - the FSM state encoding (IDLE=2'd0, LOAD=2'd1, RUN=2'd2).
- One sub-module, mic1_cs_ram: a single-port synchronous-write, registered-read RAM with a write enable and a read enable.
- The top level contains the FSM, the counter and the optional parity logic.

Test Plan:
- Reset then idle: rst low for 2 cycles -> MIR=0, word_count=0, running=0, load_ready=1.
- Load and run:
  - Load addr 0 = 36'h0_0100_0000 (NEXT_ADDR=0, JAMZ=... irrelevant), addr 5 = 36'hA_0000_0000, with last on addr 5 -> word_count=2, running=1 next cycle.
  - Then MPC=5 -> MIR=36'hA_0000_0000 one cycle later.
- Hold: in RUN, MPC switches 0->5 with hold=1 -> MIR keeps the addr-0 word; after hold drops, the next edge gives the addr-5 word.
- Load ignored in RUN: load_valid=1, addr 5, data 0 during RUN -> load_ready=0, word_count unchanged, MPC=5 still reads 36'hA_0000_0000.
- Reset mid-load: write 3 words, assert rst before load_last -> IDLE, word_count=0; run_start, then MPC = first address -> the previously written word is returned.
- Simultaneous start: in IDLE, load_valid=1 with run_start=1 and load_last=0 -> state LOAD, running=0, word_count=1.

Source files
------------

// File: rtl/mic1_pkg.sv
// Shared definitions for the MIC-1 control store: widths, MIR field
// positions and the load/run sequencer state encoding.
package mic1_pkg;

   localparam int ADDR_W = 9;
   localparam int WORD_W = 36;
   localparam int DEPTH  = 2 ** ADDR_W;

   // MIR fields read back by the control path
   localparam int NEXT_ADDR_MSB = 35;
   localparam int NEXT_ADDR_LSB = 27;
   localparam int JMPC_BIT      = 26;
   localparam int JAMN_BIT      = 25;
   localparam int JAMZ_BIT      = 24;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } cs_state_e;

endpackage

// File: rtl/mic1_control_store_if.sv
// MPC/MIR bus plus microprogram load port between the control path (master)
// and the control store (slave). parity_err exists only when
// MIC1_CS_PARITY_EN is defined.
interface mic1_control_store_if #(
   parameter int ADDR_W = 9,
   parameter int WORD_W = 36
);
   logic [ADDR_W-1:0] MPC;
   logic              hold;
   logic              load_valid;
   logic              load_ready;
   logic [ADDR_W-1:0] load_addr;
   logic [WORD_W-1:0] load_data;
   logic              load_last;
   logic              run_start;
   logic              running;
   logic [ADDR_W:0]   word_count;
   logic [WORD_W-1:0] MIR;
`ifdef MIC1_CS_PARITY_EN
   logic              parity_err;
`endif

   modport master (
      output MPC, hold, load_valid, load_addr, load_data, load_last, run_start,
      input  load_ready, running, word_count, MIR
`ifdef MIC1_CS_PARITY_EN
      , input parity_err
`endif
   );

   modport slave (
      input  MPC, hold, load_valid, load_addr, load_data, load_last, run_start,
      output load_ready, running, word_count, MIR
`ifdef MIC1_CS_PARITY_EN
      , output parity_err
`endif
   );

endinterface

// File: rtl/mic1_cs_ram.sv
// Single-port store: synchronous write, registered read. One address port
// is shared; the caller guarantees read and write never coincide.
module mic1_cs_ram #(
   parameter int AW = 9,
   parameter int DW = 36
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we_i,
   input  logic          re_i,
   input  logic [AW-1:0] addr_i,
   input  logic [DW-1:0] wdata_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem [2**AW];
   logic [DW-1:0] rdata_q;

   // Array write port.
   // NOTE: the array has no reset; a reset mid-load must keep the words already written.
   always_ff @(posedge clk) begin
      if (we_i) mem[addr_i] <= wdata_i;
   end

   // Read register: cleared by reset, updated only on an enabled read.
   always_ff @(posedge clk) begin
      if (!rst)      rdata_q <= '0;
      else if (re_i) rdata_q <= mem[addr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/mic1_control_store.sv
// MIC-1 microprogram control store: load sequencer, accepted-word counter
// and registered MIR fetch. Define MIC1_CS_PARITY_EN to store an even-parity
// bit per word and zero MIR (with a sticky parity_err) on a bad fetch.
module mic1_control_store
   import mic1_pkg::*;
(
   input logic                clk,
   input logic                rst,
   mic1_control_store_if.slave bus
);

`ifdef MIC1_CS_PARITY_EN
   localparam int PAR_W = 1;
`else
   localparam int PAR_W = 0;
`endif
   localparam int STORE_W = WORD_W + PAR_W;
   localparam logic [ADDR_W:0] COUNT_MAX = (ADDR_W + 1)'(DEPTH);

   cs_state_e         state_q, state_d;
   logic [ADDR_W:0]   word_count_q, word_count_d;
   logic              accept;
   logic              fetch;
   logic [ADDR_W-1:0] ram_addr;
   logic [STORE_W-1:0] ram_wdata;
   logic [STORE_W-1:0] ram_rdata;

   // State and counter registers.
   // NOTE: sequential blocks use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= IDLE;
         word_count_q <= '0;
      end else begin
         state_q      <= state_d;
         word_count_q <= word_count_d;
      end
   end

   // Next state, handshake and counter update; a load handshake beats run_start.
   always_comb begin
      // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
      state_d      = state_q;
      word_count_d = word_count_q;
      accept       = 1'b0;
      fetch        = 1'b0;
      unique case (state_q)
         IDLE: begin
            accept = bus.load_valid;
            if (bus.load_valid)     state_d = bus.load_last ? RUN : LOAD;
            else if (bus.run_start) state_d = RUN;
         end
         LOAD: begin
            accept = bus.load_valid;
            if (bus.load_valid && bus.load_last) state_d = RUN;
         end
         RUN: begin
            fetch = !bus.hold;
         end
         default: state_d = IDLE;
      endcase
      if (accept && word_count_q != COUNT_MAX) word_count_d = word_count_q + 1'b1;
   end

   assign bus.load_ready = (state_q != RUN);
   assign bus.running    = (state_q == RUN);
   assign bus.word_count = word_count_q;
   assign ram_addr       = (state_q == RUN) ? bus.MPC : bus.load_addr;

`ifdef MIC1_CS_PARITY_EN
   logic parity_ok;
   logic parity_err_q;

   assign ram_wdata = {^bus.load_data, bus.load_data};
   assign parity_ok = ~^ram_rdata;
   assign bus.MIR   = parity_ok ? ram_rdata[WORD_W-1:0] : '0;

   // Sticky parity error, set by any bad word sitting in the read register during RUN.
   always_ff @(posedge clk) begin
      if (!rst)                              parity_err_q <= 1'b0;
      else if (state_q == RUN && !parity_ok) parity_err_q <= 1'b1;
   end

   assign bus.parity_err = parity_err_q;
`else
   assign ram_wdata = bus.load_data;
   assign bus.MIR   = ram_rdata;
`endif

   mic1_cs_ram #(
      .AW (ADDR_W),
      .DW (STORE_W)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .we_i    (accept),
      .re_i    (fetch),
      .addr_i  (ram_addr),
      .wdata_i (ram_wdata),
      .rdata_o (ram_rdata)
   );

endmodule

// File: tb/tb_mic1_control_store.sv
// Directed bench for mic1_control_store: reset, load/run, hold, load ignored
// in RUN, reset mid-load, simultaneous load/run_start and repeated writes.
module tb_mic1_control_store;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;

   mic1_control_store_if #(.ADDR_W(9), .WORD_W(36)) cs_if ();

   mic1_control_store dut (
      .clk (clk),
      .rst (rst),
      .bus (cs_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      cs_if.MPC        = '0;
      cs_if.hold       = 1'b0;
      cs_if.load_valid = 1'b0;
      cs_if.load_addr  = '0;
      cs_if.load_data  = '0;
      cs_if.load_last  = 1'b0;
      cs_if.run_start  = 1'b0;
   endtask

   task automatic load_word(input logic [8:0] a, input logic [35:0] d, input logic last);
      cs_if.load_valid = 1'b1;
      cs_if.load_addr  = a;
      cs_if.load_data  = d;
      cs_if.load_last  = last;
      tick();
      cs_if.load_valid = 1'b0;
      cs_if.load_last  = 1'b0;
   endtask

   initial begin
      logic [35:0] mir_v;
      n_cmp = 0;
      n_bad = 0;
      idle_inputs();

      // Reset then idle
      rst = 1'b0;
      tick();
      tick();
      check("rst_mir", 64'(cs_if.MIR), 64'h0);
      check("rst_count", 64'(cs_if.word_count), 64'd0);
      check("rst_running", 64'(cs_if.running), 64'd0);
      check("rst_ready", 64'(cs_if.load_ready), 64'd1);
      rst = 1'b1;
      tick();
      check("idle_running", 64'(cs_if.running), 64'd0);

      // Load addr 0 and addr 5 (last)
      load_word(9'd0, 36'h0_0100_0000, 1'b0);
      check("load1_count", 64'(cs_if.word_count), 64'd1);
      check("load1_running", 64'(cs_if.running), 64'd0);
      check("load1_mir", 64'(cs_if.MIR), 64'h0);
      load_word(9'd5, 36'hA_0000_0000, 1'b1);
      check("load2_count", 64'(cs_if.word_count), 64'd2);
      check("load2_running", 64'(cs_if.running), 64'd1);
      check("run_ready", 64'(cs_if.load_ready), 64'd0);

      // Fetch addr 5
      cs_if.MPC = 9'd5;
      tick();
      check("fetch5", 64'(cs_if.MIR), 64'hA_0000_0000);
      mir_v = cs_if.MIR;
      check("fetch5_next_addr", 64'(mir_v[35:27]), 64'h140);

      // Hold: fetch addr 0, then switch MPC to 5 under hold
      cs_if.MPC = 9'd0;
      tick();
      check("fetch0", 64'(cs_if.MIR), 64'h0_0100_0000);
      mir_v = cs_if.MIR;
      check("fetch0_jamz", 64'(mir_v[24]), 64'd1);
      cs_if.hold = 1'b1;
      cs_if.MPC  = 9'd5;
      tick();
      check("hold1", 64'(cs_if.MIR), 64'h0_0100_0000);
      tick();
      check("hold2", 64'(cs_if.MIR), 64'h0_0100_0000);
      cs_if.hold = 1'b0;
      tick();
      check("hold_release", 64'(cs_if.MIR), 64'hA_0000_0000);

      // Load attempt during RUN is ignored
      cs_if.load_valid = 1'b1;
      cs_if.load_addr  = 9'd5;
      cs_if.load_data  = 36'h0;
      cs_if.load_last  = 1'b1;
      #1;
      check("run_load_ready", 64'(cs_if.load_ready), 64'd0);
      tick();
      check("run_load_count", 64'(cs_if.word_count), 64'd2);
      tick();
      check("run_load_mir", 64'(cs_if.MIR), 64'hA_0000_0000);
      cs_if.load_valid = 1'b0;
      cs_if.load_last  = 1'b0;

      // Reset mid-load keeps written words
      rst = 1'b0;
      tick();
      check("rst2_running", 64'(cs_if.running), 64'd0);
      check("rst2_mir", 64'(cs_if.MIR), 64'h0);
      rst = 1'b1;
      load_word(9'd10, 36'h1_2345_6789, 1'b0);
      load_word(9'd11, 36'hF_0000_000F, 1'b0);
      load_word(9'd12, 36'h0_0000_0001, 1'b0);
      check("mid_count", 64'(cs_if.word_count), 64'd3);
      check("mid_running", 64'(cs_if.running), 64'd0);
      check("mid_mir", 64'(cs_if.MIR), 64'h0);
      rst = 1'b0;
      tick();
      check("mid_rst_count", 64'(cs_if.word_count), 64'd0);
      check("mid_rst_ready", 64'(cs_if.load_ready), 64'd1);
      rst = 1'b1;
      cs_if.run_start = 1'b1;
      tick();
      cs_if.run_start = 1'b0;
      check("run_start_running", 64'(cs_if.running), 64'd1);
      check("run_start_count", 64'(cs_if.word_count), 64'd0);
      cs_if.MPC = 9'd10;
      tick();
      check("kept10", 64'(cs_if.MIR), 64'h1_2345_6789);
      cs_if.MPC = 9'd12;
      tick();
      check("kept12", 64'(cs_if.MIR), 64'h0_0000_0001);

      // Simultaneous load_valid and run_start: load wins
      rst = 1'b0;
      tick();
      rst = 1'b1;
      cs_if.run_start = 1'b1;
      load_word(9'd20, 36'h3_3333_3333, 1'b0);
      check("simul_running", 64'(cs_if.running), 64'd0);
      check("simul_count", 64'(cs_if.word_count), 64'd1);
      check("simul_ready", 64'(cs_if.load_ready), 64'd1);
      tick();
      cs_if.run_start = 1'b0;
      check("load_ignores_start", 64'(cs_if.running), 64'd0);

      // Repeated write to one address: last wins, both counted
      load_word(9'd20, 36'hC_0FFE_E123, 1'b1);
      check("rewrite_count", 64'(cs_if.word_count), 64'd2);
      check("rewrite_running", 64'(cs_if.running), 64'd1);
      cs_if.MPC = 9'd20;
      tick();
      check("rewrite_mir", 64'(cs_if.MIR), 64'hC_0FFE_E123);

`ifdef MIC1_CS_PARITY_EN
      check("parity_clean", 64'(cs_if.parity_err), 64'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
